alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Two-requester round-robin arbiter and sequencer that shares the single combinational `arithmetic_unit` in the tt_um ALU design. It accepts operations over valid/ready handshakes and drives the shared unit's operands and select with the granted requester's latched values. It holds those inputs stable for a programmable settle time, captures the 6-bit result and returns it tagged with the requester ID. It sits between the pin-level decode in the top module and `arithmetic_unit`.

## Interface
- `OPW`, default 3: operand width (A and B).
- `RESW`, default 6: result width returned by the arithmetic unit.
- `SETTLE`, default 1: number of cycles the unit's inputs are held before capture; legal range 1..7.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous reset, active-high; clears all state immediately.
- `req0_valid` / `req1_valid` in 1: requester 0/1 has an operation pending.
- `req0_ready` / `req1_ready` out 1: requester 0/1 is accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in OPW: operands.
- `req0_sel`, `req1_sel` in 2: operation select for `arithmetic_unit`.
- `alu_a`, `alu_b` out OPW: operands driven to the shared unit.
- `alu_sel` out 2: select driven to the shared unit.
- `alu_result` in RESW: combinational result from the shared unit.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester that issued the response.
- `rsp_data` out RESW: captured result.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out 8: completed responses, wraps 255 -> 0.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE, grant selection:** combinational from valids and the `last_grant` register.
  - Only one request valid: that requester wins.
  - Both valid: the requester not equal to `last_grant` wins.
  - `last_grant` resets to 1, so requester 0 wins the first contention.
- **IDLE, acceptance:** `reqN_ready` = (state == IDLE) and grant == N. At most one ready is high per cycle.
- **Accept** (valid & ready), on the same edge:
  - latch a, b, sel into operand registers
  - set `rsp_id` and `last_grant` to N
  - load the settle counter with SETTLE-1
  - go to EXEC.
- **EXEC:** `alu_a`/`alu_b`/`alu_sel` = latched operands. They are constant for the whole state. The counter decrements each cycle. When the counter is 0, capture `alu_result` into `rsp_data` and go to RESP.
- **RESP:** `rsp_valid` = 1. `rsp_data` and `rsp_id` stay stable until `rsp_valid & rsp_ready`. On that handshake:
  - go to IDLE
  - increment `op_count`.
- Operand outputs are 0 in IDLE. In RESP they hold the latched operands.
- Requests are never accepted outside IDLE. A requester's valid dropping before acceptance simply withdraws it; no state changes.
- SETTLE values outside 1..7 are unsupported; synthesis-time assertion.

## Timing
- Reset values:
  - `req0_ready` = `req1_ready` = 0 while in reset; they follow the IDLE grant rules once reset releases.
  - `alu_a` = `alu_b` = 0, `alu_sel` = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0.
  - `busy` = 0, `op_count` = 0.
- Accept at edge T. EXEC occupies cycles T+1..T+SETTLE. `alu_result` is sampled at the end of cycle T+SETTLE. `rsp_valid` is high from cycle T+SETTLE+1.
- Response handshake at cycle R. The FSM is in IDLE at R+1, and a new accept is possible at R+1.
- Peak throughput: one operation per SETTLE+2 cycles.
- With `rsp_ready` held low, RESP persists indefinitely with stable outputs. Backpressure stalls both requesters.
- Asserting `rst` in EXEC or RESP drops `rsp_valid` and `busy` immediately. The in-flight result is discarded and not counted.
- Simultaneous valid on both requesters in IDLE grants exactly one. The loser's valid must remain high to be served next.

## Test plan
- **Single op, SETTLE=1.** Stimulus: `req0` a=3, b=5, sel=2; bench drives `alu_result` = 0x2A during EXEC. Required response: `req0_ready` at T; `alu_*` = 3/5/2 at T+1; `rsp_valid` at T+2 with `rsp_data` = 0x2A and `rsp_id` = 0; `op_count` = 1 after the handshake.
- **Contention fairness.** Stimulus: both valid continuously, `rsp_ready` = 1. Required response: grants alternate 0,1,0,1 over 4 operations; each grant occurs every 3 cycles.
- **Backpressure.** Stimulus: `rsp_ready` = 0 for 10 cycles after `rsp_valid`. Required response: `rsp_data`/`rsp_id` stay stable; both readies stay 0; acceptance occurs 1 cycle after `rsp_ready` rises.
- **SETTLE=4.** Stimulus: bench changes `alu_result` each EXEC cycle (0x01, 0x02, 0x03, 0x04). Required response: captured `rsp_data` = 0x04; `alu_*` are constant for 4 cycles.
- **Reset mid-EXEC.** Stimulus: assert `rst` during EXEC. Required response: `busy` = 0 and `rsp_valid` = 0 asynchronously; `op_count` unchanged (0); after release, `req0` wins contention.
- **Counter wrap.** Stimulus: complete 256 operations. Required response: `op_count` returns to 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Round-robin arbiter and sequencer for the single combinational arithmetic_unit.
// Two requesters offer operations over valid/ready. The granted operation's
// operands and select are latched and driven to the shared unit. They are held
// for SETTLE cycles. The unit's result is then captured and returned, tagged
// with the requester ID.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req{0,1}_valid/_ready    request handshakes (ready only in IDLE, one at a time)
//   req{0,1}_a/_b/_sel       operands and operation select
//   alu_a/alu_b/alu_sel      drive to the shared unit (zero while IDLE)
//   alu_result               combinational result from the shared unit
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/rsp_data          requester tag and captured result
//   busy                     high whenever the sequencer is not IDLE
//   op_count                 completed responses, wraps at 256

// Elaboration-time guard on the settle parameter.
module alu_share_arbiter_param_chk #(
   parameter int SETTLE = 1
) ();
   generate
      if (SETTLE < 1 || SETTLE > 7) begin : g_bad_settle
         $error("alu_share_arbiter: SETTLE must be within 1..7");
      end
   endgenerate
endmodule

module alu_share_arbiter #(
   parameter int OPW    = 3,
   parameter int RESW   = 6,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OPW-1:0]  req0_a,
   input  logic [OPW-1:0]  req0_b,
   input  logic [1:0]      req0_sel,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OPW-1:0]  req1_a,
   input  logic [OPW-1:0]  req1_b,
   input  logic [1:0]      req1_sel,
   output logic [OPW-1:0]  alu_a,
   output logic [OPW-1:0]  alu_b,
   output logic [1:0]      alu_sel,
   input  logic [RESW-1:0] alu_result,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [RESW-1:0] rsp_data,
   output logic            busy,
   output logic [7:0]      op_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic            grant_s;
   logic            accept_s;
   logic            capture_s;
   logic            rsp_done_s;
   logic            last_grant_r;
   logic [2:0]      cnt_r;
   logic [OPW-1:0]  alu_a_r;
   logic [OPW-1:0]  alu_b_r;
   logic [1:0]      alu_sel_r;
   logic            rsp_valid_r;
   logic            rsp_id_r;
   logic [RESW-1:0] rsp_data_r;
   logic            busy_r;
   logic [7:0]      op_count_r;

   alu_share_arbiter_param_chk #(.SETTLE(SETTLE)) u_param_chk ();

   // Grant selection: a lone requester wins, contention goes to the one not served last.
   always_comb begin
      grant_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_s = ~last_grant_r;
      end else if (req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = 1'b0;
      end
   end

   // Readies are forced low while reset is held, even though the state already reads IDLE.
   assign req0_ready = (state_r == IDLE) && !rst && (grant_s == 1'b0);
   assign req1_ready = (state_r == IDLE) && !rst && (grant_s == 1'b1);

   // Next-state logic and the datapath enables for each transition.
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      capture_s   = 1'b0;
      rsp_done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            accept_s = grant_s ? req1_valid : req0_valid;
            if (accept_s) begin
               state_nxt_s = EXEC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: begin
            if (cnt_r == 3'd0) begin
               capture_s   = 1'b1;
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = EXEC;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_done_s  = 1'b1;
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand latch, settle counter, result capture and response bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_r <= 1'b1;
         cnt_r        <= 3'd0;
         alu_a_r      <= '0;
         alu_b_r      <= '0;
         alu_sel_r    <= 2'd0;
         rsp_valid_r  <= 1'b0;
         rsp_id_r     <= 1'b0;
         rsp_data_r   <= '0;
         busy_r       <= 1'b0;
         op_count_r   <= 8'd0;
      end else begin
         if (accept_s) begin
            alu_a_r      <= grant_s ? req1_a : req0_a;
            alu_b_r      <= grant_s ? req1_b : req0_b;
            alu_sel_r    <= grant_s ? req1_sel : req0_sel;
            rsp_id_r     <= grant_s;
            last_grant_r <= grant_s;
            cnt_r        <= 3'(SETTLE - 1);
            busy_r       <= 1'b1;
         end else if (capture_s) begin
            rsp_data_r  <= alu_result;
            rsp_valid_r <= 1'b1;
         end else if (rsp_done_s) begin
            // Operands return to zero so the shared unit sees a quiet bus in IDLE.
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            alu_sel_r   <= 2'd0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            op_count_r  <= op_count_r + 8'd1;
         end else if (state_r == EXEC) begin
            cnt_r <= cnt_r - 3'd1;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign alu_sel   = alu_sel_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_id    = rsp_id_r;
   assign rsp_data  = rsp_data_r;
   assign busy      = busy_r;
   assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed cases plus randomized traffic,
// checked by a scoreboard against a transaction-level reference model.
module tb_alu_share_arbiter;

   localparam int S1 = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       v0, v1, rdy0, rdy1, rsp_ready, rsp_valid, rsp_id, busy;
   logic [2:0] a0, b0, a1, b1, alu_a, alu_b;
   logic [1:0] s0, s1, alu_sel;
   logic [5:0] alu_res, rsp_data;
   logic [7:0] op_count;
   logic       ovr_en;
   logic [5:0] ovr_val;

   // second instance with a longer settle time
   logic       d4_v0, d4_rdy0, d4_v1, d4_rdy1, d4_rsp_ready, d4_rsp_valid, d4_rsp_id, d4_busy;
   logic [2:0] d4_a0, d4_b0, d4_a1, d4_b1, d4_alu_a, d4_alu_b;
   logic [1:0] d4_s0, d4_s1, d4_alu_sel;
   logic [5:0] d4_res, d4_rsp_data;
   logic [7:0] d4_op_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.OPW(3), .RESW(6), .SETTLE(S1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(v0), .req0_ready(rdy0), .req0_a(a0), .req0_b(b0), .req0_sel(s0),
      .req1_valid(v1), .req1_ready(rdy1), .req1_a(a1), .req1_b(b1), .req1_sel(s1),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_res),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy), .op_count(op_count)
   );

   alu_share_arbiter #(.OPW(3), .RESW(6), .SETTLE(4)) dut4 (
      .clk(clk), .rst(rst),
      .req0_valid(d4_v0), .req0_ready(d4_rdy0), .req0_a(d4_a0), .req0_b(d4_b0), .req0_sel(d4_s0),
      .req1_valid(d4_v1), .req1_ready(d4_rdy1), .req1_a(d4_a1), .req1_b(d4_b1), .req1_sel(d4_s1),
      .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_sel(d4_alu_sel), .alu_result(d4_res),
      .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_id(d4_rsp_id), .rsp_data(d4_rsp_data),
      .busy(d4_busy), .op_count(d4_op_count)
   );

   // Stand-in for the shared arithmetic unit.
   function automatic logic [5:0] alu_fn(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sel);
      case (sel)
         2'd0:    return {3'b000, a} + {3'b000, b};
         2'd1:    return {3'b000, a} * {3'b000, b};
         2'd2:    return {a, b};
         default: return {b, a};
      endcase
   endfunction

   always_comb begin
      alu_res = ovr_en ? ovr_val : alu_fn(alu_a, alu_b, alu_sel);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model and scoreboard ----------------
   typedef struct {
      logic       id;
      logic [2:0] a;
      logic [2:0] b;
      logic [1:0] sel;
      logic [5:0] data;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   cyc        = 0;
   bit   mdl_busy   = 1'b0;
   bit   mdl_last   = 1'b1;
   int   mdl_total  = 0;
   int   mdl_acc    = 0;

   always @(negedge clk) begin
      int   w;
      exp_t e;
      bit   exp_v;
      cyc++;
      if (rst) begin
         q.delete();
         mdl_busy  = 1'b0;
         mdl_last  = 1'b1;
         mdl_total = 0;
         mdl_acc   = 0;
      end else begin
         chk("busy", 32'(busy), 32'(mdl_busy));
         chk("op_count", 32'(op_count), 32'(mdl_total % 256));
         chk("ready_onehot", 32'(rdy0 & rdy1), 32'd0);
         if (mdl_busy && q.size() > 0) begin
            e     = q[0];
            exp_v = (cyc >= e.cyc + S1 + 1);
            chk("alu_a_held", 32'(alu_a), 32'(e.a));
            chk("alu_b_held", 32'(alu_b), 32'(e.b));
            chk("alu_sel_held", 32'(alu_sel), 32'(e.sel));
            chk("rsp_valid_timing", 32'(rsp_valid), 32'(exp_v));
            chk("ready_while_busy", 32'({rdy0, rdy1}), 32'd0);
            if (exp_v && rsp_valid) begin
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
               if (rsp_ready) begin
                  void'(q.pop_front());
                  mdl_total++;
                  mdl_busy = 1'b0;
               end
            end
         end else begin
            chk("alu_idle_zero", 32'({alu_a, alu_b, alu_sel}), 32'd0);
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            w = -1;
            if (v0 && v1)  w = mdl_last ? 0 : 1;
            else if (v0)   w = 0;
            else if (v1)   w = 1;
            chk("grant", 32'({v0 & rdy0, v1 & rdy1}),
                (w == 0) ? 32'd2 : ((w == 1) ? 32'd1 : 32'd0));
            if ((w == 0 && rdy0) || (w == 1 && rdy1)) begin
               e.id   = (w == 1);
               e.a    = (w == 1) ? a1 : a0;
               e.b    = (w == 1) ? b1 : b0;
               e.sel  = (w == 1) ? s1 : s0;
               e.data = ovr_en ? ovr_val : alu_fn(e.a, e.b, e.sel);
               e.cyc  = cyc;
               q.push_back(e);
               mdl_busy = 1'b1;
               mdl_last = (w == 1);
               mdl_acc++;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_acc(output int id, output int t);
      id = -1;
      t  = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (v0 && rdy0) begin
            id = 0; t = int'($time / 10); break;
         end else if (v1 && rdy1) begin
            id = 1; t = int'($time / 10); break;
         end
      end
      if (id < 0) chk("accept_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy && !rsp_valid) begin
            done = 1'b1; break;
         end
      end
      if (!done) chk("drain_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- directed and random stimulus ----------------
   initial begin
      int  id, t, prev;
      bit  found, acc0, acc1;
      rst = 1'b1; v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b0;
      a0 = 3'd0; b0 = 3'd0; s0 = 2'd0; a1 = 3'd0; b1 = 3'd0; s1 = 2'd0;
      ovr_en = 1'b0; ovr_val = 6'd0;
      d4_v0 = 1'b1; d4_v1 = 1'b0; d4_a0 = 3'd0; d4_b0 = 3'd0; d4_s0 = 2'd0;
      d4_a1 = 3'd0; d4_b1 = 3'd0; d4_s1 = 2'd0; d4_res = 6'd0; d4_rsp_ready = 1'b0;

      // reset values, readies gated by reset even with valids high
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", 32'(rdy0), 32'd0);
      chk("rst_ready1", 32'(rdy1), 32'd0);
      chk("rst_d4_ready0", 32'(d4_rdy0), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
      chk("rst_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; v0 = 1'b0; v1 = 1'b0; d4_v0 = 1'b0;

      // single operation, SETTLE=1
      @(posedge clk); #1;
      v0 = 1'b1; a0 = 3'd3; b0 = 3'd5; s0 = 2'd2; ovr_en = 1'b1; ovr_val = 6'h2A; rsp_ready = 1'b1;
      @(negedge clk);
      chk("single_ready0", 32'(rdy0), 32'd1);
      @(posedge clk); #1;
      v0 = 1'b0;
      @(negedge clk);
      chk("single_alu", 32'({alu_a, alu_b, alu_sel}), 32'({3'd3, 3'd5, 2'd2}));
      chk("single_exec_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_rsp", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b0, 6'h2A}));
      @(posedge clk); #1;
      ovr_en = 1'b0;
      @(negedge clk);
      chk("single_op_count", 32'(op_count), 32'd1);
      chk("single_busy", 32'(busy), 32'd0);

      // reset in EXEC discards the in-flight operation
      @(posedge clk); #1;
      v1 = 1'b1; a1 = 3'd7; b1 = 3'd2; s1 = 2'd1;
      wait_acc(id, t);
      chk("rst_exec_grant", 32'(id), 32'd1);
      @(posedge clk); #1;
      v1 = 1'b0;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_exec_busy", 32'(busy), 32'd0);
      chk("rst_exec_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk("rst_exec_op_count", 32'(op_count), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // contention: alternating grants, one every SETTLE+2 cycles
      v0 = 1'b1; v1 = 1'b1; rsp_ready = 1'b1;
      a0 = 3'd1; b0 = 3'd2; s0 = 2'd0; a1 = 3'd6; b1 = 3'd3; s1 = 2'd3;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_acc(id, t);
         chk("contend_id", 32'(id), 32'(k % 2));
         if (k > 0) chk("contend_gap", 32'(t - prev), 32'(S1 + 2));
         prev = t;
         @(posedge clk); #1;
         a0 = 3'($urandom); b0 = 3'($urandom); s0 = 2'($urandom);
         a1 = 3'($urandom); b1 = 3'($urandom); s1 = 2'($urandom);
      end
      v0 = 1'b0; v1 = 1'b0;
      drain();

      // backpressure: response held, both requesters stalled
      rsp_ready = 1'b0; v0 = 1'b1; a0 = 3'd1; b0 = 3'd6; s0 = 2'd0;
      ovr_en = 1'b1; ovr_val = 6'h15;
      wait_acc(id, t);
      chk("bp_grant", 32'(id), 32'd0);
      @(posedge clk); #1;
      v1 = 1'b1; a1 = 3'd5; b1 = 3'd5; s1 = 2'd3; a0 = 3'd2;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            found = 1'b1; break;
         end
      end
      chk("bp_valid_seen", 32'(found), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_data}), 32'({1'b1, 1'b0, 6'h15}));
         chk("bp_readies", 32'({rdy0, rdy1}), 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1; ovr_en = 1'b0;
      @(negedge clk);
      chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_accept_next", 32'({rdy0, rdy1}), 32'd1);
      @(posedge clk); #1;
      v0 = 1'b0; v1 = 1'b0;
      drain();

      // SETTLE=4: operands held four cycles, last EXEC-cycle result captured
      d4_v0 = 1'b1; d4_a0 = 3'd6; d4_b0 = 3'd1; d4_s0 = 2'd3;
      @(negedge clk);
      chk("s4_ready0", 32'(d4_rdy0), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         d4_v0 = 1'b0; d4_res = 6'(i);
         @(negedge clk);
         chk("s4_alu_held", 32'({d4_alu_a, d4_alu_b, d4_alu_sel}), 32'({3'd6, 3'd1, 2'd3}));
         chk("s4_exec_valid", 32'(d4_rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      d4_res = 6'h3F;
      @(negedge clk);
      chk("s4_rsp", 32'({d4_rsp_valid, d4_rsp_id, d4_rsp_data}), 32'({1'b1, 1'b0, 6'h04}));
      @(posedge clk); #1;
      d4_rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("s4_op_count", 32'(d4_op_count), 32'd1);

      // randomized traffic with random backpressure and occasional withdrawal
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         acc0 = v0 && rdy0;
         acc1 = v1 && rdy1;
         @(posedge clk); #1;
         if (!v0 || acc0) begin
            v0 = 1'($urandom_range(0, 1));
            a0 = 3'($urandom); b0 = 3'($urandom); s0 = 2'($urandom);
         end else if ($urandom_range(0, 7) == 0) begin
            v0 = 1'b0;
         end
         if (!v1 || acc1) begin
            v1 = 1'($urandom_range(0, 1));
            a1 = 3'($urandom); b1 = 3'($urandom); s1 = 2'($urandom);
         end else if ($urandom_range(0, 7) == 0) begin
            v1 = 1'b0;
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end

      // complete exactly 256 operations since the last reset
      @(posedge clk); #1;
      v1 = 1'b0; rsp_ready = 1'b1;
      for (int g = 0; g < 3000 && mdl_total < 256; g++) begin
         @(posedge clk); #1;
         v0 = (mdl_acc < 256);
         a0 = 3'($urandom); b0 = 3'($urandom); s0 = 2'($urandom);
      end
      v0 = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("wrap_total", 32'(mdl_total), 32'd256);
      chk("wrap_op_count", 32'(op_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
